// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared state encoding, default pattern and ui_in bit positions for fsm_seq_detector
package fsm_seq_pkg;
  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;
  localparam logic [3:0] PATTERN_DEF = 4'b1011;
  localparam int BIT_IDX   = 0;
  localparam int VALID_IDX = 1;
  localparam int CLR_IDX   = 2;
endpackage

// File: rtl/fsm_seq_detector_if.sv
// fsm_seq_detector_if: tiny-tapeout user pin frame bundled for the sequence detector
interface fsm_seq_detector_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/fsm_seq_counter.sv
// fsm_seq_counter: wrapping detection counter with sync clear taking priority over increment
module fsm_seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || i_clr) ? '0 : i_inc ? r_cnt + 1'b1 : r_cnt;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/fsm_seq_detector.sv
// fsm_seq_detector: Moore "1011" serial detector; define FSM_OVERLAP_EN for overlapping matches
module fsm_seq_detector
  import fsm_seq_pkg::*;
#(
  parameter logic [3:0] PATTERN = PATTERN_DEF,
  parameter int         CNT_W   = 8
) (
  input logic                clk,
  input logic                rst,
  fsm_seq_detector_if.slave  io
);
`ifdef FSM_OVERLAP_EN
  localparam state_t DONE_ON0 = S10;
`else
  localparam state_t DONE_ON0 = S0;
`endif
  state_t           r_state, w_next;
  logic [3:0]       r_hist;
  logic [CNT_W-1:0] w_cnt;
  logic             w_bit, w_acc, w_clr;
  assign w_bit = io.ui_in[BIT_IDX];
  assign w_acc = io.ena & io.ui_in[VALID_IDX];
  assign w_clr = io.ena & io.ui_in[CLR_IDX];
  // illegal codes fall through to default and recover to S0 even without an accepted bit
  always_comb begin
    w_next = r_state;
    case (r_state)
      S0:      w_next = w_acc ? (w_bit ? S1 : S0) : r_state;
      S1:      w_next = w_acc ? (w_bit ? S1 : S10) : r_state;
      S10:     w_next = w_acc ? (w_bit ? S101 : S0) : r_state;
      S101:    w_next = w_acc ? (w_bit ? S1011 : S10) : r_state;
      S1011:   w_next = w_acc ? (w_bit ? S1 : DONE_ON0) : r_state;
      default: w_next = S0;
    endcase
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? S0 : io.ena ? w_next : r_state;
    r_hist  <= rst ? 4'h0 : w_acc ? {r_hist[2:0], w_bit} : r_hist;
  end
  fsm_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_inc (w_acc && w_next == S1011 && r_state != S1011),
    .o_cnt (w_cnt)
  );
  assign io.uo_out  = {r_hist, r_state, r_state == S1011};
  assign io.uio_out = w_cnt;
  assign io.uio_oe  = 8'hFF;
  logic w_unused;
  assign w_unused = &{1'b0, io.ui_in[7:3], io.uio_in, PATTERN};
endmodule

// File: tb/tb_fsm_seq_detector.sv
// tb_fsm_seq_detector: directed-vector self-checking bench for fsm_seq_detector
module tb_fsm_seq_detector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  fsm_seq_detector_if io ();
  fsm_seq_detector dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
`ifdef FSM_OVERLAP_EN
  localparam logic [7:0] OVL_CNT = 8'd2;
  localparam logic [7:0] OVL_UO  = 8'hB9;
`else
  localparam logic [7:0] OVL_CNT = 8'd1;
  localparam logic [7:0] OVL_UO  = 8'hB2;
`endif
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic b, input logic v, input logic c, input logic e);
    io.ena    = e;
    io.ui_in  = {5'($urandom), c, v, b};
    io.uio_in = 8'($urandom);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      io.ena    = 1'($urandom);
      io.ui_in  = 8'($urandom);
      io.uio_in = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask
  task automatic send(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b1);
  endtask
  logic [7:0] gap_uo [4] = '{8'h12, 8'h24, 8'h56, 8'hB9};
  logic [3:0] pat = 4'b1011;
  initial begin
    io.ena = 1'b0; io.ui_in = '0; io.uio_in = '0;
    do_reset();
    check("reset_uo", io.uo_out, 8'h00);
    check("reset_uio", io.uio_out, 8'h00);
    check("reset_oe", io.uio_oe, 8'hFF);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    check("basic_mid_uo", io.uo_out, 8'h24);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    check("basic_uo", io.uo_out, 8'hB9);
    check("basic_cnt", io.uio_out, 8'd1);
    do_reset();
    send(4'b1011);
    for (int i = 2; i >= 0; i--) step(pat[i], 1, 0, 1);
    check("ovl_cnt", io.uio_out, OVL_CNT);
    check("ovl_uo", io.uo_out, OVL_UO);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(pat[3-i], 1, 0, 1);
      check($sformatf("gap_acc%0d", i), io.uo_out, gap_uo[i]);
      repeat (3) step(1'($urandom), 0, 0, 1);
      check($sformatf("gap_hold%0d", i), io.uo_out, gap_uo[i]);
    end
    check("gap_cnt", io.uio_out, 8'd1);
    do_reset();
    for (int i = 0; i < 255; i++) send(4'b1011);
    check("cnt_255", io.uio_out, 8'd255);
    send(4'b1011);
    check("cnt_wrap", io.uio_out, 8'd0);
    send(4'b1011);
    check("cnt_after_wrap", io.uio_out, 8'd1);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 1, 1);
    check("clr_vs_inc_cnt", io.uio_out, 8'd0);
    check("clr_vs_inc_det", io.uo_out, 8'hB9);
    do_reset();
    send(4'b1011);
    for (int i = 3; i >= 0; i--) step(pat[i] ^ 1'b1, 1, 1, 0);
    check("ena_uo", io.uo_out, 8'hB9);
    check("ena_cnt", io.uio_out, 8'd1);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    rst = 1'b1;
    step(1, 1, 0, 1);
    rst = 1'b0;
    check("midrst_uo", io.uo_out, 8'h00);
    check("midrst_cnt", io.uio_out, 8'd0);
    step(1, 1, 0, 1);
    check("midrst_one_uo", io.uo_out, 8'h12);
    check("midrst_one_cnt", io.uio_out, 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
